// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - big-endian byte RAM answering the CPU MOV/RW/MOC handshake
// Optional misaligned-access detection (ERR) under `define MEM_ALIGN_CHECK_EN.
module mem_responder #(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MOV,
    input  logic        RW,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    input  logic [1:0]  Size,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        ERR
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(LATENCY + 2);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               rw_q, rw_d;
    logic [1:0]         size_q, size_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        dout_q, dout_d;
    logic               moc_q, moc_d;
    logic               err_q, err_d;

    logic [7:0]         mem [DEPTH];
    logic [ADDR_W-1:0]  eff_addr;
    logic [ADDR_W-1:0]  lane_addr [4];
    logic [7:0]         wr_byte [4];
    logic [3:0]         lane_mask;
    logic [3:0]         we;
    logic [31:0]        rdata;
    logic               misaligned;
    logic               unused_addr_hi;

    assign unused_addr_hi = ^Address[31:ADDR_W];

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        eff_addr   = addr_q;
        misaligned = ((size_q == 2'b01) && addr_q[0]) || (size_q[1] && (addr_q[1:0] != 2'b00));
    end
`else
    // Without checking, the low address bits are silently dropped to the access size.
    always_comb begin
        misaligned = 1'b0;
        case (size_q)
            2'b00:   eff_addr = addr_q;
            2'b01:   eff_addr = {addr_q[ADDR_W-1:1], 1'b0};
            default: eff_addr = {addr_q[ADDR_W-1:2], 2'b00};
        endcase
    end
`endif

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_addr[i] = eff_addr + ADDR_W'(i);
        end
        wr_byte[0] = wdata_q[31:24];
        wr_byte[1] = wdata_q[23:16];
        wr_byte[2] = wdata_q[15:8];
        wr_byte[3] = wdata_q[7:0];
        lane_mask  = 4'b1111;
        rdata      = {mem[lane_addr[0]], mem[lane_addr[1]], mem[lane_addr[2]], mem[lane_addr[3]]};
        case (size_q)
            2'b00: begin
                wr_byte[0] = wdata_q[7:0];
                lane_mask  = 4'b0001;
                rdata      = {24'h0, mem[lane_addr[0]]};
            end
            2'b01: begin
                wr_byte[0] = wdata_q[15:8];
                wr_byte[1] = wdata_q[7:0];
                lane_mask  = 4'b0011;
                rdata      = {16'h0, mem[lane_addr[0]], mem[lane_addr[1]]};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        moc_d   = moc_q;
        err_d   = err_q;
        we      = 4'b0000;
        case (state_q)
            S_IDLE: begin
                if (MOV) begin
                    addr_d  = Address[ADDR_W-1:0];
                    rw_d    = RW;
                    size_d  = Size;
                    wdata_d = DataIn;
                    cnt_d   = CNT_W'(LATENCY);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    moc_d   = 1'b1;
                    err_d   = misaligned;
                    state_d = S_DONE;
                    if (rw_q) begin
                        dout_d = misaligned ? 32'h0 : rdata;
                    end else if (!misaligned) begin
                        we = lane_mask;
                    end
                end
            end
            S_DONE: begin
                if (!MOV) begin
                    moc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            size_q  <= 2'b00;
            wdata_q <= 32'h0;
            dout_q  <= 32'h0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            moc_q   <= moc_d;
            err_q   <= err_d;
        end
    end

    // Array has no reset; reset only suppresses a write that is completing this edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!reset && we[i]) begin
                mem[lane_addr[i]] <= wr_byte[i];
            end
        end
    end

    assign DataOut = dout_q;
    assign MOC     = moc_q;
    assign ERR     = err_q;
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's MOV/RW/MOC memory handshake.
- Holds a byte-addressable, big-endian RAM (instruction and data).
- Captures a request when MOV rises, waits a programmable latency, performs the byte/halfword/word access and raises MOC.
- Drives DataOut, which the datapath loads into IR or MDR.

Parameters:
ADDR_W, 9, byte-address bits used; depth = 2**ADDR_W bytes; upper address bits ignored (wrap).
LATENCY, 2, wait cycles between request capture and access completion; 0 is legal.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
MOV  input  1  memory operation valid from CPU; level-held until MOC seen
RW  input  1  1 = read, 0 = write
Address  input  32  byte address (MAR)
DataIn  input  32  write data (MDR), right-justified for byte/halfword
Size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
DataOut  output  32  read data, right-justified, zero-extended
MOC  output  1  memory operation complete
ERR  output  1  misaligned access flag (see Optional Feature)

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset: state IDLE, MOC=0, ERR=0, DataOut=0, latency counter=0.
- Reset aborts any in-flight request; a pending write is not committed.
- Reset does not clear array contents. No array initialisation is performed by RTL; benches preload via hierarchical write or $readmemh.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On an edge with MOV=1: capture Address[ADDR_W-1:0], RW, Size and DataIn into internal registers, load counter=LATENCY, go to WAIT.
  - Later changes on the inputs are ignored until the next capture.
- WAIT:
  - If counter != 0: decrement.
  - If counter == 0: perform the access on this edge, set MOC=1, go to DONE.
  - MOC therefore rises on edge t+1+LATENCY, where t is the capture edge.
- Access uses the captured values; big-endian byte order:
  - Byte: byte at A.
  - Halfword: bytes A (MSB), A+1.
  - Word: bytes A..A+3, A MSB.
- Alignment without the feature: halfword forces A[0]=0; word forces A[1:0]=0.
- Read: DataOut updated on the completion edge, zero-extended; the datapath sign extender handles signedness.
- Write: array updated on the completion edge; DataOut unchanged.
- Byte-address arithmetic wraps modulo 2**ADDR_W.
- DONE:
  - MOC and DataOut held stable while MOV=1.
  - On an edge with MOV=0: MOC=0 (and ERR=0), go to IDLE.
  - A new request needs MOV low for at least one edge, so back-to-back requests are separated by at least one IDLE cycle.
- MOV deasserted during WAIT: the request still completes. MOC pulses for one cycle in DONE, then drops because MOV=0.
- Exactly one array write per request regardless of how long MOV stays high.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Halfword with A[0]=1, or word with A[1:0]!=0, is misaligned.
  - Misaligned write: no array change.
  - Misaligned read: DataOut=0.
  - Completion timing and MOC are unchanged.
  - ERR=1 asserted together with MOC and cleared with it.
- Undefined: ERR tied 0; addresses are force-aligned as in Behaviour.

Test Plan:
- Reset then word write: Address=0x10, DataIn=0xDEADBEEF, Size=10, RW=0, MOV=1, LATENCY=2 -> MOC rises exactly 3 edges after capture; bytes 0x10..0x13 = DE AD BE EF.
- Word read back at 0x10 -> DataOut=0xDEADBEEF with MOC; then byte read at 0x11 -> 0x000000AD; halfword read at 0x12 -> 0x0000BEEF.
- Byte write 0x55 to 0x13, then word read at 0x10 -> 0xDEADBE55; verify only one write per request while MOV held 10 cycles.
- Handshake: hold MOV high 5 cycles after MOC -> MOC and DataOut stable; drop MOV -> MOC=0 next edge; change Address during WAIT -> original address used.
- Reset asserted in WAIT of a write to 0x20 -> MOC=0, state IDLE, byte 0x20 unchanged; LATENCY=0 build -> MOC 1 edge after capture.
- With MEM_ALIGN_CHECK_EN: word write to 0x11 -> ERR=1 with MOC, memory unchanged. Without the macro: same write lands at 0x10.
